// File: rtl/result_overlay_pkg.sv
// rtl/result_overlay_pkg.sv - shared FSM type and constants for the result overlay
// Holds the overlay state enum, the default-width DNF marker and the default caption colour.

package result_overlay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNAP    = 3'd1,
    ST_COMPARE = 3'd2,
    ST_SHOW    = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  // Upper bound on players; arrays are sized to this so a 2-bit index is always in range.
  localparam int MAX_PLAYERS = 4;

  localparam int DEF_TIME_W = 22;

  // A player that did not finish reports an all-ones time.
  localparam logic [DEF_TIME_W-1:0] DNF_TIME = '1;

  localparam logic [11:0] DEF_CAP_COLOR = 12'hfd0;

endpackage

// File: rtl/delay.sv
// rtl/delay.sv - fixed-length register delay line
// Ports:
//   clk, reset   pixel clock, asynchronous active-high reset
//   din          WIDTH-bit input word
//   dout         din delayed by LEN clock cycles

module delay #(
  parameter int WIDTH = 1,
  parameter int LEN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [LEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LEN; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < LEN; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[LEN-1];

endmodule

// File: rtl/result_arbiter.sv
// rtl/result_arbiter.sv - snapshot and sequential minimum-time search over all players
// Ports:
//   clk, reset     pixel clock, asynchronous active-high reset
//   snap           latch time_in and restart the search
//   compare        examine one player per cycle, index 0 upward
//   time_in        packed player times, player 0 in the LSBs, all-ones = DNF
//   winner_idx     first index holding the minimum time
//   draw           two or more finishers share the minimum
//   winner_valid   a unique finisher holds the minimum
//   done           high on the cycle that examines the last player

module result_arbiter
  import result_overlay_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 22
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        snap,
  input  logic                        compare,
  input  logic [N_PLAYERS*TIME_W-1:0] time_in,
  output logic [1:0]                  winner_idx,
  output logic                        draw,
  output logic                        winner_valid,
  output logic                        done
);

  localparam logic [TIME_W-1:0] DNF  = '1;
  localparam logic [1:0]        LAST = 2'(N_PLAYERS - 1);

  logic [TIME_W-1:0] times_q [MAX_PLAYERS];
  logic [TIME_W-1:0] best;
  logic [TIME_W-1:0] cur;
  logic [1:0]        best_idx;
  logic [1:0]        cnt;
  logic              tie;

  assign cur  = times_q[cnt];
  assign done = compare && (cnt == LAST);

  // The running minimum starts at DNF, so a DNF entry can never displace it and
  // never counts as a tie: an all-DNF field ends with index 0, no tie, no winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_PLAYERS; i++) times_q[i] <= DNF;
      best     <= DNF;
      best_idx <= 2'd0;
      cnt      <= 2'd0;
      tie      <= 1'b0;
    end else if (snap) begin
      for (int i = 0; i < N_PLAYERS; i++) times_q[i] <= time_in[i*TIME_W +: TIME_W];
      best     <= DNF;
      best_idx <= 2'd0;
      cnt      <= 2'd0;
      tie      <= 1'b0;
    end else if (compare) begin
      cnt <= cnt + 2'd1;
      if (cur < best) begin
        best     <= cur;
        best_idx <= cnt;
        tie      <= 1'b0;
      end else if ((cur == best) && (cur != DNF)) begin
        tie <= 1'b1;
      end
    end
  end

  assign winner_idx   = best_idx;
  assign draw         = tie;
  assign winner_valid = (best != DNF) && !tie;

endmodule

// File: rtl/result_overlay.sv
// rtl/result_overlay.sv - end-of-race winner/draw caption overlay on the VGA stream
// Optional feature macro: RESULT_BLINK_EN (blinking caption, steady once acknowledged).
// Ports:
//   clk, reset                    pixel clock, asynchronous active-high reset
//   end_game_status               result screen active
//   keyboard_in                   acknowledge key
//   time_in                       packed player times, player 0 in the LSBs, all-ones = DNF
//   hcount_in, vcount_in          timing counters
//   hsync_in, vsync_in            syncs
//   hblnk_in, vblnk_in            blanking
//   rgb_in                        upstream pixel
//   pixel_bits_caption            caption ROM data (1-cycle latency), bit k = player k wins, top bit = draw
//   pixel_addr                    caption ROM address {row, col}
//   hsync_out, vsync_out, rgb_out registered video, 2 cycles after the inputs
//   key_press_status              acknowledge latched
//   winner_idx, winner_valid, draw  race result while the result is shown

module result_overlay
  import result_overlay_pkg::*;
#(
  parameter int          N_PLAYERS = 2,
  parameter int          TIME_W    = 22,
  parameter int          CAP_HPOS  = 330,
  parameter int          CAP_VPOS  = 200,
  parameter int          CAP_W     = 512,
  parameter int          CAP_H     = 43,
  parameter logic [11:0] CAP_COLOR = DEF_CAP_COLOR
`ifdef RESULT_BLINK_EN
  ,
  parameter int          BLINK_FRAMES = 30
`endif
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     end_game_status,
  input  logic                                     keyboard_in,
  input  logic [N_PLAYERS*TIME_W-1:0]              time_in,
  input  logic [10:0]                              hcount_in,
  input  logic [10:0]                              vcount_in,
  input  logic                                     hsync_in,
  input  logic                                     vsync_in,
  input  logic                                     hblnk_in,
  input  logic                                     vblnk_in,
  input  logic [11:0]                              rgb_in,
  input  logic [N_PLAYERS:0]                       pixel_bits_caption,
  output logic [$clog2(CAP_H)+$clog2(CAP_W)-1:0]   pixel_addr,
  output logic                                     hsync_out,
  output logic                                     vsync_out,
  output logic [11:0]                              rgb_out,
  output logic                                     key_press_status,
  output logic [1:0]                               winner_idx,
  output logic                                     winner_valid,
  output logic                                     draw
);

  localparam int ROW_W      = $clog2(CAP_H);
  localparam int COL_W      = $clog2(CAP_W);
  localparam int VID_W      = 12 + 11 + 11 + 4;
  localparam int CAP_BITS_W = MAX_PLAYERS + 1;

  state_t state;

  logic [1:0] arb_idx;
  logic       arb_draw;
  logic       arb_valid;
  logic       arb_done;

  logic [VID_W-1:0] vid_d;
  logic [11:0]      rgb_d;
  logic [10:0]      hcount_d;
  logic [10:0]      vcount_d;
  logic             hsync_d, vsync_d, hblnk_d, vblnk_d;

  logic                  showing;
  logic                  in_window;
  logic [CAP_BITS_W-1:0] cap_bits;
  logic                  cap_bit;
  logic                  caption_on;
  logic [11:0]           rgb_next;

  // The ROM is addressed from the undelayed counters; its data lines up with the delayed ones.
  assign pixel_addr = {ROW_W'(vcount_in - 11'(CAP_VPOS)), COL_W'(hcount_in - 11'(CAP_HPOS))};

  delay #(
    .WIDTH (VID_W),
    .LEN   (1)
  ) u_vid_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({rgb_in, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in}),
    .dout  (vid_d)
  );

  assign {rgb_d, hcount_d, vcount_d, hsync_d, vsync_d, hblnk_d, vblnk_d} = vid_d;

  result_arbiter #(
    .N_PLAYERS (N_PLAYERS),
    .TIME_W    (TIME_W)
  ) u_arbiter (
    .clk          (clk),
    .reset        (reset),
    .snap         (state == ST_SNAP),
    .compare      (state == ST_COMPARE),
    .time_in      (time_in),
    .winner_idx   (arb_idx),
    .draw         (arb_draw),
    .winner_valid (arb_valid),
    .done         (arb_done)
  );

  // Dropping end_game_status wins over every transition, aborting a search in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (!end_game_status) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state <= ST_SNAP;
        ST_SNAP:    state <= ST_COMPARE;
        ST_COMPARE: if (arb_done) state <= ST_SHOW;
        ST_SHOW:    if (keyboard_in) state <= ST_ACK;
        ST_ACK:     state <= ST_ACK;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign showing          = (state == ST_SHOW) || (state == ST_ACK);
  assign key_press_status = (state == ST_ACK);
  assign winner_valid     = showing && arb_valid;
  assign draw             = showing && arb_draw;
  assign winner_idx       = showing ? arb_idx : 2'd0;

  assign in_window = (32'(hcount_d) >= CAP_HPOS) && (32'(hcount_d) < CAP_HPOS + CAP_W) &&
                     (32'(vcount_d) >= CAP_VPOS) && (32'(vcount_d) < CAP_VPOS + CAP_H);

  // Zero-pad to the widest build so the 2-bit winner index always selects in range.
  assign cap_bits = CAP_BITS_W'(pixel_bits_caption);

  always_comb begin
    cap_bit = 1'b0;
    if (arb_draw)       cap_bit = pixel_bits_caption[N_PLAYERS];
    else if (arb_valid) cap_bit = cap_bits[{1'b0, arb_idx}];
  end

`ifdef RESULT_BLINK_EN
  logic        vsync_prev;
  logic [15:0] frame_cnt;
  logic        blink_phase;
  logic        enter_show;

  assign enter_show = end_game_status && (state == ST_COMPARE) && arb_done;

  // Frames are counted on the delayed vsync so the phase flips on the frame boundary
  // the output stream actually sees. Each result screen starts with the caption visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_prev  <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      vsync_prev <= vsync_d;
      if (enter_show) begin
        frame_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (vsync_d && !vsync_prev) begin
        if (32'(frame_cnt) == BLINK_FRAMES - 1) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end

  assign caption_on = blink_phase || (state == ST_ACK);
`else
  assign caption_on = 1'b1;
`endif

  always_comb begin
    rgb_next = rgb_d;
    if (showing) begin
      if (hblnk_d || vblnk_d)                    rgb_next = 12'h000;
      else if (in_window && cap_bit && caption_on) rgb_next = CAP_COLOR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb_out   <= 12'h000;
    end else begin
      hsync_out <= hsync_d;
      vsync_out <= vsync_d;
      rgb_out   <= rgb_next;
    end
  end

endmodule
